// File: rtl/scheduler_spawnout_mq_pkg.sv
// Shared OmpSs manager constants for the multi-queue spawn-out writer:
// header field offsets, new-task type word fields and the header packer.
package scheduler_spawnout_mq_pkg;

    localparam int ENTRY_VALID_BYTE_OFFSET = 56;
    localparam int NUM_ARGS_OFFSET         = 32;
    localparam int NUM_DEPS_OFFSET         = 40;
    localparam int NUM_COPS_OFFSET         = 48;

    localparam int CMD_NEWTASK_TASKTYPE_L  = 0;
    localparam int CMD_NEWTASK_ARCHMASK_L  = 32;

    localparam int DEFAULT_COPY_WORDS      = 3;

    localparam logic [7:0] ENTRY_VALID_BYTE = 8'h80;

    function automatic logic [63:0] make_header(input logic [3:0] args,
                                                input logic [3:0] deps,
                                                input logic [3:0] cops);
        logic [63:0] hdr;
        hdr = '0;
        hdr[ENTRY_VALID_BYTE_OFFSET +: 8] = ENTRY_VALID_BYTE;
        hdr[NUM_ARGS_OFFSET +: 8]         = {4'd0, args};
        hdr[NUM_DEPS_OFFSET +: 8]         = {4'd0, deps};
        hdr[NUM_COPS_OFFSET +: 8]         = {4'd0, cops};
        return hdr;
    endfunction

endpackage

// File: rtl/scheduler_spawnout_mq_if.sv
// Memory port and payload stream of the spawn-out writer.
// master = the writer block, slave = memory/stream environment.
interface scheduler_spawnout_mq_if;

    logic [31:0] mem_addr;
    logic        mem_en;
    logic [7:0]  mem_we;
    logic [63:0] mem_din;
    logic [63:0] mem_dout;

    logic        in_tvalid;
    logic        in_tready;
    logic [63:0] in_tdata;
    logic        in_tlast;

    modport master (
        output mem_addr, mem_en, mem_we, mem_din,
        input  mem_dout,
        input  in_tvalid, in_tdata, in_tlast,
        output in_tready
    );

    modport slave (
        input  mem_addr, mem_en, mem_we, mem_din,
        output mem_dout,
        output in_tvalid, in_tdata, in_tlast,
        input  in_tready
    );

endinterface

// File: rtl/scheduler_spawnout_mq_slot_calc.sv
// Registered slot count of a task entry: 4 + args + deps + cops*COPY_WORDS.
module spawnout_slot_calc
    import scheduler_spawnout_mq_pkg::*;
#(
    parameter int COPY_WORDS = DEFAULT_COPY_WORDS,
    parameter int SLOT_BITS  = 7
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic [3:0]           args,
    input  logic [3:0]           deps,
    input  logic [3:0]           cops,
    output logic [SLOT_BITS-1:0] slots
);

    logic [SLOT_BITS-1:0] slots_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            slots_reg <= '0;
        end else if (en) begin
            slots_reg <= SLOT_BITS'(4) + SLOT_BITS'(args) + SLOT_BITS'(deps)
                       + SLOT_BITS'(cops) * SLOT_BITS'(COPY_WORDS);
        end
    end

    assign slots = slots_reg;

endmodule

// File: rtl/scheduler_spawnout_mq.sv
// Multi-queue spawn-out writer: reclaims host-consumed slots, writes task
// entries into per-queue rings of a shared BRAM and commits with the header last.
module scheduler_spawnout_mq
    import scheduler_spawnout_mq_pkg::*;
#(
    parameter int NUM_QUEUES    = 4,
    parameter int QUEUE_LEN     = 1024,
    parameter int QUEUE_BITS    = $clog2(QUEUE_LEN),
    parameter int QSEL_BITS     = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
    parameter int COPY_WORDS    = DEFAULT_COPY_WORDS,
    parameter int TASKTYPE_BITS = 32,
    parameter int ARCHBITS_BITS = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    scheduler_spawnout_mq_if.master  bus,
    input  logic                     start,
    input  logic [QSEL_BITS-1:0]     queue_sel,
    input  logic [63:0]              task_id,
    input  logic [63:0]              ptask_id,
    input  logic [TASKTYPE_BITS-1:0] task_type,
    input  logic [ARCHBITS_BITS-1:0] task_arch,
    input  logic [3:0]               num_args,
    input  logic [3:0]               num_deps,
    input  logic [3:0]               num_cops,
    output logic                     busy,
    output logic [1:0]               ret,
    output logic                     err_tlast
);

    // One extra value so the largest possible entry size is representable.
    localparam int SLOT_BITS  = $clog2(34 + 15 * COPY_WORDS + 1);
    localparam int AVAIL_BITS = QUEUE_BITS + 1;
    localparam int CMP_BITS   = (SLOT_BITS > AVAIL_BITS) ? SLOT_BITS : AVAIL_BITS;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CHECK, ST_READ, ST_CALC, ST_RECLAIM,
        ST_TID, ST_PTID, ST_TYPE, ST_PAY, ST_HDR
    } spawnout_mq_state_t;

    spawnout_mq_state_t state_reg, state_next;

    logic [QSEL_BITS-1:0]     q_reg;
    logic [63:0]              task_id_reg, ptask_id_reg;
    logic [TASKTYPE_BITS-1:0] task_type_reg;
    logic [ARCHBITS_BITS-1:0] task_arch_reg;
    logic [3:0]               num_args_reg, num_deps_reg, num_cops_reg;
    logic [3:0]               hdr_args_reg, hdr_deps_reg, hdr_cops_reg;

    logic [QUEUE_BITS-1:0]    widx_reg  [NUM_QUEUES];
    logic [QUEUE_BITS-1:0]    ridx_reg  [NUM_QUEUES];
    logic [AVAIL_BITS-1:0]    avail_reg [NUM_QUEUES];

    logic [QUEUE_BITS-1:0]    ptr_reg;
    logic [SLOT_BITS-1:0]     rem_reg;
    logic [1:0]               ret_reg;
    logic                     err_tlast_reg;

    logic [SLOT_BITS-1:0]     needed, reclaim_slots;
    logic [QUEUE_BITS-1:0]    cur_widx, cur_ridx, mem_idx;
    logic [AVAIL_BITS-1:0]    cur_avail;
    logic                     fits, reject_hit, last_beat;
    logic                     mem_en_c, in_tready_c;
    logic [7:0]               mem_we_c;
    logic [63:0]              mem_din_c, type_word;
    logic                     unused_dout_bits;

    assign cur_widx  = widx_reg[q_reg];
    assign cur_ridx  = ridx_reg[q_reg];
    assign cur_avail = avail_reg[q_reg];
    assign fits      = CMP_BITS'(needed) <= CMP_BITS'(cur_avail);
    assign last_beat = (rem_reg == SLOT_BITS'(1));
    // An empty queue has nothing to reclaim, so an oversized request is refused.
    assign reject_hit = bus.mem_dout[ENTRY_VALID_BYTE_OFFSET + 7]
                     || (cur_avail == AVAIL_BITS'(QUEUE_LEN));
    assign unused_dout_bits = ^bus.mem_dout;

    spawnout_slot_calc #(.COPY_WORDS(COPY_WORDS), .SLOT_BITS(SLOT_BITS)) u_req_calc (
        .clk   (clk),
        .rstn  (rstn),
        .en    (state_reg == ST_IDLE && start),
        .args  (num_args),
        .deps  (num_deps),
        .cops  (num_cops),
        .slots (needed)
    );

    spawnout_slot_calc #(.COPY_WORDS(COPY_WORDS), .SLOT_BITS(SLOT_BITS)) u_reclaim_calc (
        .clk   (clk),
        .rstn  (rstn),
        .en    (state_reg == ST_CALC),
        .args  (hdr_args_reg),
        .deps  (hdr_deps_reg),
        .cops  (hdr_cops_reg),
        .slots (reclaim_slots)
    );

    always_comb begin
        type_word = '0;
        type_word[CMD_NEWTASK_TASKTYPE_L +: TASKTYPE_BITS] = task_type_reg;
        type_word[CMD_NEWTASK_ARCHMASK_L +: ARCHBITS_BITS] = task_arch_reg;
    end

    always_comb begin
        state_next  = state_reg;
        mem_en_c    = 1'b0;
        mem_we_c    = 8'hFF;
        mem_idx     = '0;
        mem_din_c   = '0;
        in_tready_c = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                mem_en_c   = 1'b1;
                mem_we_c   = 8'h00;
                mem_idx    = cur_ridx;
                state_next = fits ? ST_TID : ST_READ;
            end
            ST_READ:    state_next = reject_hit ? ST_IDLE : ST_CALC;
            ST_CALC:    state_next = ST_RECLAIM;
            ST_RECLAIM: state_next = ST_CHECK;
            ST_TID: begin
                mem_en_c   = 1'b1;
                mem_idx    = cur_widx + QUEUE_BITS'(1);
                mem_din_c  = task_id_reg;
                state_next = ST_PTID;
            end
            ST_PTID: begin
                mem_en_c   = 1'b1;
                mem_idx    = cur_widx + QUEUE_BITS'(2);
                mem_din_c  = ptask_id_reg;
                state_next = ST_TYPE;
            end
            ST_TYPE: begin
                mem_en_c   = 1'b1;
                mem_idx    = cur_widx + QUEUE_BITS'(3);
                mem_din_c  = type_word;
                state_next = (needed == SLOT_BITS'(4)) ? ST_HDR : ST_PAY;
            end
            ST_PAY: begin
                in_tready_c = 1'b1;
                mem_en_c    = bus.in_tvalid;
                mem_idx     = ptr_reg;
                mem_din_c   = bus.in_tdata;
                if (bus.in_tvalid && last_beat) state_next = ST_HDR;
            end
            ST_HDR: begin
                mem_en_c   = 1'b1;
                mem_idx    = cur_widx;
                mem_din_c  = make_header(num_args_reg, num_deps_reg, num_cops_reg);
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_din   = mem_din_c;
    assign bus.mem_addr  = (32'(q_reg) * 32'(QUEUE_LEN) + 32'(mem_idx)) << 3;
    assign bus.in_tready = in_tready_c;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            q_reg         <= '0;
            task_id_reg   <= '0;
            ptask_id_reg  <= '0;
            task_type_reg <= '0;
            task_arch_reg <= '0;
            num_args_reg  <= '0;
            num_deps_reg  <= '0;
            num_cops_reg  <= '0;
            hdr_args_reg  <= '0;
            hdr_deps_reg  <= '0;
            hdr_cops_reg  <= '0;
            ptr_reg       <= '0;
            rem_reg       <= '0;
            ret_reg       <= 2'd0;
            err_tlast_reg <= 1'b0;
            for (int i = 0; i < NUM_QUEUES; i++) begin
                widx_reg[i]  <= '0;
                ridx_reg[i]  <= '0;
                avail_reg[i] <= AVAIL_BITS'(QUEUE_LEN);
            end
        end else begin
            state_reg <= state_next;
            ret_reg   <= 2'd0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        q_reg         <= queue_sel & QSEL_BITS'(NUM_QUEUES - 1);
                        task_id_reg   <= task_id;
                        ptask_id_reg  <= ptask_id;
                        task_type_reg <= task_type;
                        task_arch_reg <= task_arch;
                        num_args_reg  <= num_args;
                        num_deps_reg  <= num_deps;
                        num_cops_reg  <= num_cops;
                    end
                end
                ST_READ: begin
                    hdr_args_reg <= bus.mem_dout[NUM_ARGS_OFFSET +: 4];
                    hdr_deps_reg <= bus.mem_dout[NUM_DEPS_OFFSET +: 4];
                    hdr_cops_reg <= bus.mem_dout[NUM_COPS_OFFSET +: 4];
                    if (reject_hit) ret_reg <= 2'd2;
                end
                ST_RECLAIM: begin
                    avail_reg[q_reg] <= cur_avail + AVAIL_BITS'(reclaim_slots);
                    ridx_reg[q_reg]  <= cur_ridx + QUEUE_BITS'(reclaim_slots);
                end
                ST_TYPE: begin
                    ptr_reg <= cur_widx + QUEUE_BITS'(4);
                    rem_reg <= needed - SLOT_BITS'(4);
                end
                ST_PAY: begin
                    if (bus.in_tvalid) begin
                        ptr_reg <= ptr_reg + QUEUE_BITS'(1);
                        rem_reg <= rem_reg - SLOT_BITS'(1);
                        if (bus.in_tlast != last_beat) err_tlast_reg <= 1'b1;
                    end
                end
                ST_HDR: begin
                    widx_reg[q_reg]  <= cur_widx + QUEUE_BITS'(needed);
                    avail_reg[q_reg] <= cur_avail - AVAIL_BITS'(needed);
                    ret_reg          <= 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg != ST_IDLE);
    assign ret       = ret_reg;
    assign err_tlast = err_tlast_reg;

endmodule
